// File: rtl/otter_pkg.sv
// Shared types for the OTTER decode/execute boundary: ALU function codes, major opcodes,
// immediate formats and operand source selects.
package otter_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSll  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluSrl  = 4'b0101,
    AluOr   = 4'b0110,
    AluAnd  = 4'b0111,
    AluSub  = 4'b1000,
    AluLui  = 4'b1001,
    AluSra  = 4'b1101
  } alu_fun_t;

  typedef enum logic [6:0] {
    OpOp     = 7'b0110011,
    OpOpImm  = 7'b0010011,
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpBranch = 7'b1100011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011
  } opcode_t;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_t;

  typedef enum logic [1:0] {SrcARs1, SrcAPc, SrcAImmU} src_a_t;

  typedef enum logic [1:0] {SrcBRs2, SrcBImm, SrcBShamt} src_b_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ID-side inputs and EX-side ALU operand/control outputs of the decode/execute register.
// ALU_CTRL_FWD_EN adds the EX/MEM and MEM/WB forwarding inputs.
interface alu_ctrl_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned FUN_W = 4
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
`ifdef ALU_CTRL_FWD_EN
  logic [4:0]       exmem_rd;
  logic             exmem_we;
  logic [XLEN-1:0]  exmem_result;
  logic [4:0]       memwb_rd;
  logic             memwb_we;
  logic [XLEN-1:0]  memwb_result;
`endif
  logic             out_valid;
  logic [FUN_W-1:0] ALU_fun;
  logic [XLEN-1:0]  ALU_scra;
  logic [XLEN-1:0]  ALU_scrb;
  logic [XLEN-1:0]  rs2_out;
  logic [4:0]       rd_addr;
  logic             reg_we;
  logic             mem_we;
  logic             mem_re;
  logic             illegal;

  modport master (
    input  in_valid, stall, flush, instr, pc, rs1_data, rs2_data,
`ifdef ALU_CTRL_FWD_EN
    input  exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result,
`endif
    output out_valid, ALU_fun, ALU_scra, ALU_scrb, rs2_out, rd_addr, reg_we, mem_we, mem_re,
    output illegal
  );

  modport slave (
    output in_valid, stall, flush, instr, pc, rs1_data, rs2_data,
`ifdef ALU_CTRL_FWD_EN
    output exmem_rd, exmem_we, exmem_result, memwb_rd, memwb_we, memwb_result,
`endif
    input  out_valid, ALU_fun, ALU_scra, ALU_scrb, rs2_out, rd_addr, reg_we, mem_we, mem_re,
    input  illegal
  );

endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: all five immediate formats, sign-extended from instr[31].
module imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

endmodule

// File: rtl/alu_ctrl_stage.sv
// Decode-to-execute pipeline register: decodes RV32I into ALU function/operands and writeback
// control, one cycle latency, flush > stall > load. ALU_CTRL_FWD_EN enables operand forwarding.
module alu_ctrl_stage
  import otter_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned FUN_W = 4
) (
  input logic               CLK,
  input logic               RST_N,
  alu_ctrl_stage_if.master  bus
);

  typedef struct packed {
    logic             valid;
    logic [FUN_W-1:0] fun;
    logic [XLEN-1:0]  scra;
    logic [XLEN-1:0]  scrb;
    logic [XLEN-1:0]  rs2;
    logic [4:0]       rd;
    logic             reg_we;
    logic             mem_we;
    logic             mem_re;
    logic             illegal;
  } stage_t;

  stage_t stage_d, stage_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign rd     = bus.instr[11:7];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (bus.instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef ALU_CTRL_FWD_EN
  // MEM/WB applied first so EX/MEM, the younger result, overrides it.
  always_comb begin
    rs1_val = bus.rs1_data;
    rs2_val = bus.rs2_data;
    if (bus.memwb_we && (bus.memwb_rd != 5'd0)) begin
      if (bus.memwb_rd == bus.instr[19:15]) rs1_val = bus.memwb_result;
      if (bus.memwb_rd == bus.instr[24:20]) rs2_val = bus.memwb_result;
    end
    if (bus.exmem_we && (bus.exmem_rd != 5'd0)) begin
      if (bus.exmem_rd == bus.instr[19:15]) rs1_val = bus.exmem_result;
      if (bus.exmem_rd == bus.instr[24:20]) rs2_val = bus.exmem_result;
    end
  end
`else
  assign rs1_val = bus.rs1_data;
  assign rs2_val = bus.rs2_data;
`endif

  logic       dec_legal;
  logic [3:0] dec_fun;
  logic       dec_we, dec_mwe, dec_mre;
  src_a_t     src_a;
  src_b_t     src_b;
  imm_type_t  imm_sel;

  always_comb begin
    dec_legal = 1'b1;
    dec_fun   = AluAdd;
    dec_we    = 1'b0;
    dec_mwe   = 1'b0;
    dec_mre   = 1'b0;
    src_a     = SrcARs1;
    src_b     = SrcBImm;
    imm_sel   = ImmI;
    unique case (opcode)
      OpOp: begin
        dec_fun = {funct7[5], funct3};
        src_b   = SrcBRs2;
        dec_we  = 1'b1;
        if (funct7 == 7'b0100000) dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        else                      dec_legal = (funct7 == 7'b0000000);
      end
      OpOpImm: begin
        // funct7 is only meaningful for shifts; elsewhere those bits are immediate.
        dec_fun = {funct7[5] & (funct3 == 3'b101), funct3};
        dec_we  = 1'b1;
        if (funct3 == 3'b001) begin
          src_b     = SrcBShamt;
          dec_legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          src_b     = SrcBShamt;
          dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
      end
      OpLui: begin
        dec_fun = AluLui;
        src_a   = SrcAImmU;
        dec_we  = 1'b1;
      end
      OpAuipc: begin
        src_a   = SrcAPc;
        imm_sel = ImmU;
        dec_we  = 1'b1;
      end
      OpJal: begin
        src_a   = SrcAPc;
        imm_sel = ImmJ;
        dec_we  = 1'b1;
      end
      OpJalr: dec_we = 1'b1;
      OpBranch: begin
        src_a   = SrcAPc;
        imm_sel = ImmB;
      end
      OpLoad: begin
        dec_mre = 1'b1;
        dec_we  = 1'b1;
      end
      OpStore: begin
        imm_sel = ImmS;
        dec_mwe = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] imm_val, op_a, op_b;

  always_comb begin
    unique case (imm_sel)
      ImmS:    imm_val = imm_s;
      ImmB:    imm_val = imm_b;
      ImmU:    imm_val = imm_u;
      ImmJ:    imm_val = imm_j;
      default: imm_val = imm_i;
    endcase
    unique case (src_a)
      SrcAPc:   op_a = bus.pc;
      SrcAImmU: op_a = imm_u;
      default:  op_a = rs1_val;
    endcase
    unique case (src_b)
      SrcBImm:   op_b = imm_val;
      SrcBShamt: op_b = XLEN'(bus.instr[24:20]);
      default:   op_b = rs2_val;
    endcase
  end

  // Illegal instructions load a bubble that only carries the illegal flag.
  always_comb begin
    stage_d = '0;
    if (bus.in_valid) begin
      if (!dec_legal) begin
        stage_d.illegal = 1'b1;
      end else begin
        stage_d.valid  = 1'b1;
        stage_d.fun    = FUN_W'(dec_fun);
        stage_d.scra   = op_a;
        stage_d.scrb   = op_b;
        stage_d.rs2    = rs2_val;
        stage_d.rd     = rd;
        stage_d.reg_we = dec_we && (rd != 5'd0);
        stage_d.mem_we = dec_mwe;
        stage_d.mem_re = dec_mre;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage_q <= '0;
    end else if (bus.flush) begin
      stage_q <= '0;
    end else if (!bus.stall) begin
      stage_q <= stage_d;
    end
  end

  assign bus.out_valid = stage_q.valid;
  assign bus.ALU_fun   = stage_q.fun;
  assign bus.ALU_scra  = stage_q.scra;
  assign bus.ALU_scrb  = stage_q.scrb;
  assign bus.rs2_out   = stage_q.rs2;
  assign bus.rd_addr   = stage_q.rd;
  assign bus.reg_we    = stage_q.reg_we;
  assign bus.mem_we    = stage_q.mem_we;
  assign bus.mem_re    = stage_q.mem_re;
  assign bus.illegal   = stage_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: the driver queues the expected register contents for
// every edge it issues, a negedge monitor pops and compares. ALU_CTRL_FWD_EN adds forwarding cases.
module tb_alu_ctrl_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_stage_if #(.XLEN(32), .FUN_W(4)) bus ();

  alu_ctrl_stage #(
    .XLEN  (32),
    .FUN_W (4)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  // ca/cb/cr: whether scra/scrb/rs2_out are checked for this entry.
  typedef struct packed {
    logic        v;
    logic [3:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0]  rd;
    logic        we;
    logic        mwe;
    logic        mre;
    logic        ill;
    logic        ca;
    logic        cb;
    logic        cr;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t mk(logic [3:0] fun, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                              logic we);
    exp_t e;
    e = '0;
    e.v = 1'b1; e.fun = fun; e.a = a; e.b = b; e.rd = rd; e.we = we;
    e.ca = 1'b1; e.cb = 1'b1;
    return e;
  endfunction

  function automatic exp_t bub(logic ill);
    exp_t e;
    e = '0;
    e.ill = ill;
    e.ca = 1'b1; e.cb = 1'b1; e.cr = 1'b1;
    return e;
  endfunction

  task automatic check_out(input exp_t e, input string nm);
    logic ok;
    checks++;
    ok = (bus.out_valid === e.v) && (bus.ALU_fun === e.fun) && (bus.rd_addr === e.rd) &&
         (bus.reg_we === e.we) && (bus.mem_we === e.mwe) && (bus.mem_re === e.mre) &&
         (bus.illegal === e.ill) && (!e.ca || (bus.ALU_scra === e.a)) &&
         (!e.cb || (bus.ALU_scrb === e.b)) && (!e.cr || (bus.rs2_out === e.r));
    if (!ok) begin
      errors++;
      $display("FAIL %s: got v=%b fun=%b a=%h b=%h r=%h rd=%0d we=%b mwe=%b mre=%b ill=%b ; want v=%b fun=%b a=%h b=%h r=%h rd=%0d we=%b mwe=%b mre=%b ill=%b",
               nm, bus.out_valid, bus.ALU_fun, bus.ALU_scra, bus.ALU_scrb, bus.rs2_out,
               bus.rd_addr, bus.reg_we, bus.mem_we, bus.mem_re, bus.illegal,
               e.v, e.fun, e.a, e.b, e.r, e.rd, e.we, e.mwe, e.mre, e.ill);
    end
  endtask

  initial begin
    forever begin
      exp_t  e;
      string s;
      @(negedge clk);
      if (eq.size() > 0) begin
        e = eq.pop_front();
        s = nq.pop_front();
        check_out(e, s);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = v; bus.instr = ins; bus.pc = pc; bus.rs1_data = r1; bus.rs2_data = r2;
  endtask

  task automatic cyc(input exp_t e, input string nm);
    @(posedge clk);
    eq.push_back(e);
    nq.push_back(nm);
    #1;
  endtask

  exp_t e, esub;

  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ALU_CTRL_FWD_EN
    bus.exmem_rd = 5'd0; bus.exmem_we = 1'b0; bus.exmem_result = 32'h0;
    bus.memwb_rd = 5'd0; bus.memwb_we = 1'b0; bus.memwb_result = 32'h0;
`endif
    #1;
    check_out(bub(1'b0), "reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    esub = mk(4'b1000, 32'd10, 32'd3, 5'd3, 1'b1);
    drive(1'b1, 32'h402081B3, 32'h100, 32'd10, 32'd3);
    cyc(esub, "sub");
    drive(1'b1, 32'h40435293, 32'h104, 32'h80000000, 32'h0);
    cyc(mk(4'b1101, 32'h80000000, 32'd4, 5'd5, 1'b1), "srai");
    drive(1'b1, 32'h00435293, 32'h108, 32'h80000000, 32'h0);
    cyc(mk(4'b0101, 32'h80000000, 32'd4, 5'd5, 1'b1), "srli");
    drive(1'b1, 32'h123453B7, 32'h10C, 32'h0, 32'h0);
    e = mk(4'b1001, 32'h12345000, 32'h0, 5'd7, 1'b1); e.cb = 1'b0;
    cyc(e, "lui");
    drive(1'b1, 32'hFE20AE23, 32'h110, 32'h100, 32'hAB);
    e = mk(4'b0000, 32'h100, 32'hFFFFFFFC, 5'd28, 1'b0); e.mwe = 1'b1; e.r = 32'hAB; e.cr = 1'b1;
    cyc(e, "sw");
    drive(1'b1, 32'h40008093, 32'h114, 32'd5, 32'h0);
    cyc(mk(4'b0000, 32'd5, 32'h400, 5'd1, 1'b1), "addi_bit30");
    drive(1'b1, 32'hFFF00093, 32'h118, 32'd7, 32'h0);
    cyc(mk(4'b0000, 32'd7, 32'hFFFFFFFF, 5'd1, 1'b1), "addi_neg");
    drive(1'b1, 32'h00001297, 32'h11C, 32'h0, 32'h0);
    cyc(mk(4'b0000, 32'h11C, 32'h1000, 5'd5, 1'b1), "auipc");
    drive(1'b1, 32'h0080A303, 32'h120, 32'h200, 32'h0);
    e = mk(4'b0000, 32'h200, 32'd8, 5'd6, 1'b1); e.mre = 1'b1;
    cyc(e, "lw");
    drive(1'b1, 32'h004100E7, 32'h124, 32'h300, 32'h0);
    cyc(mk(4'b0000, 32'h300, 32'd4, 5'd1, 1'b1), "jalr");
    drive(1'b1, 32'h010000EF, 32'h128, 32'h0, 32'h0);
    cyc(mk(4'b0000, 32'h128, 32'h10, 5'd1, 1'b1), "jal");
    drive(1'b1, 32'hFE208CE3, 32'h200, 32'h1, 32'h2);
    cyc(mk(4'b0000, 32'h200, 32'hFFFFFFF8, 5'd25, 1'b0), "beq");
    drive(1'b1, 32'h00208033, 32'h204, 32'd1, 32'd2);
    cyc(mk(4'b0000, 32'd1, 32'd2, 5'd0, 1'b0), "add_rd0");

    drive(1'b1, 32'h0000007F, 32'h208, 32'h0, 32'h0);
    cyc(bub(1'b1), "illegal_opcode");
    drive(1'b0, 32'h0000007F, 32'h20C, 32'h0, 32'h0);
    cyc(bub(1'b0), "illegal_pulse_end");
    drive(1'b1, 32'h02208133, 32'h210, 32'h1, 32'h2);
    cyc(bub(1'b1), "illegal_funct7");
    drive(1'b1, 32'h40209133, 32'h214, 32'h1, 32'h2);
    cyc(bub(1'b1), "illegal_f7_f3");
    drive(1'b1, 32'h40409293, 32'h218, 32'h1, 32'h0);
    cyc(bub(1'b1), "illegal_shift");
    drive(1'b0, 32'h402081B3, 32'h21C, 32'd10, 32'd3);
    cyc(bub(1'b0), "in_valid_low");

    drive(1'b1, 32'h402081B3, 32'h220, 32'd10, 32'd3);
    cyc(esub, "pre_stall");
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h123453B7 + (i << 7), 32'h224 + 4 * i, 32'h5, 32'h6);
      cyc(esub, "stall_hold");
    end
    bus.flush = 1'b1;
    cyc(bub(1'b0), "flush_stall");
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(1'b1, 32'h0000007F, 32'h230, 32'h0, 32'h0);
    cyc(bub(1'b1), "ill_pre_stall");
    bus.stall = 1'b1;
    drive(1'b1, 32'h402081B3, 32'h234, 32'd10, 32'd3);
    cyc(bub(1'b1), "ill_stall_hold");
    bus.stall = 1'b0;

`ifdef ALU_CTRL_FWD_EN
    bus.exmem_rd = 5'd1; bus.exmem_we = 1'b1; bus.exmem_result = 32'h55;
    bus.memwb_rd = 5'd1; bus.memwb_we = 1'b1; bus.memwb_result = 32'h66;
    drive(1'b1, 32'h00008233, 32'h300, 32'h11, 32'h22);
    cyc(mk(4'b0000, 32'h55, 32'h22, 5'd4, 1'b1), "fwd_exmem");
    bus.exmem_we = 1'b0;
    cyc(mk(4'b0000, 32'h66, 32'h22, 5'd4, 1'b1), "fwd_memwb");
    bus.exmem_rd = 5'd0; bus.exmem_we = 1'b1; bus.memwb_rd = 5'd0;
    drive(1'b1, 32'h00000233, 32'h304, 32'h77, 32'h22);
    cyc(mk(4'b0000, 32'h77, 32'h22, 5'd4, 1'b1), "fwd_x0");
    bus.exmem_we = 1'b0; bus.memwb_we = 1'b0;
`endif

    drive(1'b1, 32'h402081B3, 32'h240, 32'd10, 32'd3);
    cyc(esub, "pre_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_out(bub(1'b0), "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    cyc(bub(1'b0), "post_reset");

    @(negedge clk);
    #1;
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", eq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Decode-to-execute pipeline register for the pipelined OTTER MCU; it is the producer side of the ALU operand/function interface.
- Decodes a 32-bit RV32I instruction into the ALU's 4-bit function code, selects and registers operands A/B, and generates immediates.
- Registers writeback control; supports stall and flush.
- One-cycle latency; the ALU in EX consumes its outputs directly.

Parameters:
- XLEN, 32, datapath width.
- FUN_W, 4, ALU function code width.

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- in_valid  in  1  ID holds a valid instruction
- stall  in  1  hold all outputs (hazard unit)
- flush  in  1  squash: next output is a bubble
- instr  in  32  instruction word
- pc  in  XLEN  instruction address
- rs1_data  in  XLEN  register file read port 1
- rs2_data  in  XLEN  register file read port 2
- out_valid  out  1  registered outputs valid
- ALU_fun  out  FUN_W  ALU function code
- ALU_scra  out  XLEN  operand A
- ALU_scrb  out  XLEN  operand B
- rs2_out  out  XLEN  store data
- rd_addr  out  5  destination register
- reg_we  out  1  writeback enable
- mem_we  out  1  store
- mem_re  out  1  load
- illegal  out  1  illegal instruction pulse

Behaviour:
- Reset: all outputs 0 while RST_N=0, asserted asynchronously and released synchronously to CLK. ALU_fun=0000.
- Latency: one CLK edge from instr to outputs.
- Update priority, per edge: flush > stall > load.
  - flush: outputs become a bubble.
  - stall without flush: every output register holds its value.
  - otherwise: load the decoded values.
- Bubble: out_valid, reg_we, mem_we, mem_re and illegal are 0, and ALU_fun=0000. Data fields are don't-care but are driven to 0.
- in_valid=0: load a bubble.
- ALU_fun encodings: add 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, sub 1000, lui 1001, sra 1101.
- OP (0110011): ALU_fun={funct7[5],funct3}; scra=rs1; scrb=rs2; reg_we=1.
- OP-IMM (0010011):
  - ALU_fun={funct7[5]&(funct3==101),funct3}; scrb=sign-extended I-immediate.
  - slli/srli/srai: scrb=zero-extended shamt.
  - reg_we=1.
- LUI: ALU_fun=1001; scra=U-immediate; reg_we=1.
- AUIPC: add; scra=pc; scrb=U-immediate; reg_we=1.
- JAL: add; scra=pc; scrb=J-immediate; reg_we=1.
- JALR: add; scra=rs1; scrb=I-immediate; reg_we=1.
- BRANCH: add; scra=pc; scrb=B-immediate, giving the target; reg_we=0. The comparison is handled outside this block.
- LOAD: add; scra=rs1; scrb=I-immediate; mem_re=1; reg_we=1.
- STORE: add; scra=rs1; scrb=S-immediate; mem_we=1; rs2_out=rs2.
- rd_addr=instr[11:7].
- rd_addr=0 forces reg_we=0.
- Illegal instruction cases:
  - unknown opcode;
  - OP with funct7 not in {0000000, 0100000};
  - funct7=0100000 with funct3 not 000/101;
  - OP-IMM shift with a bad funct7.
- Illegal result: load a bubble, except illegal=1. The pulse lasts one cycle unless held by stall.
- Immediates are sign-extended from instruction bit 31; B and J immediates have bit0=0.

Optional Feature:
- Macro: ALU_CTRL_FWD_EN.
- Defined: adds inputs exmem_rd[5], exmem_we, exmem_result[XLEN], memwb_rd[5], memwb_we, memwb_result[XLEN].
  - rs1_data and rs2_data are replaced before operand selection when a matching rd is nonzero and its we is set.
  - EX/MEM has priority over MEM/WB.
  - x0 is never forwarded.
- Undefined: no extra ports; rs data is used directly.

Decomposition:
- Package otter_pkg holds:
  - alu_fun_t enum (the 11 codes above);
  - opcode_t enum (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE);
  - immediate type enum (I, S, B, U, J).
- Sub-module imm_gen (combinational): instr → five sign-extended immediates.
- Forwarding mux is inline in this block.

Test Plan:
- `sub x3,x1,x2` (0x402081B3), rs1=10, rs2=3 → after 1 edge: ALU_fun=1000, scra=10, scrb=3, rd_addr=3, reg_we=1, out_valid=1.
- `srai x5,x6,4` (0x40435293), rs1=0x80000000 → ALU_fun=1101, scrb=4. `lui x7,0x12345` → ALU_fun=1001, scra=0x12345000.
- `sw x2,-4(x1)` (0xFE20AE23), rs1=0x100, rs2=0xAB → ALU_fun=0000, scrb=0xFFFFFFFC, mem_we=1, reg_we=0, rs2_out=0xAB.
- Stall for 3 cycles while instr changes → outputs unchanged. flush and stall together → bubble next edge, out_valid=0.
- Opcode 0x7F → illegal=1 for one cycle, reg_we=0, out_valid=0. RST_N pulled low mid-stream → all outputs 0 immediately.
- ALU_CTRL_FWD_EN defined: exmem_rd=1, exmem_we=1, exmem_result=0x55, memwb_rd=1 (result 0x66), `add x4,x1,x0` → scra=0x55. With rd=0 forwarding → no forward.
